// File: rtl/sdc_bridge_pkg.sv
// Shared state encoding and lane-reversal helper for the Wishbone-to-Avalon
// master bridge.
package sdc_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        RDWAIT = 2'd2,
        ACK    = 2'd3
    } bridge_state_t;

    // Source bit index for output bit idx when the lanes of a lanes*lane_w
    // vector are reversed (lane 0 <-> lane lanes-1); bit order inside a lane is kept.
    function automatic int unsigned lane_src_bit(input int unsigned idx,
                                                 input int unsigned lanes,
                                                 input int unsigned lane_w);
        return (lanes - 1 - idx / lane_w) * lane_w + idx % lane_w;
    endfunction

endpackage

// File: rtl/byte_lane_swap.sv
// Static lane reversal: pure wiring when ENABLE=1, straight through otherwise.
// LANE_W=8 swaps bytes of a data bus, LANE_W=1 reverses a byte-select vector.
module byte_lane_swap
    import sdc_bridge_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANE_W = 8,
    parameter bit          ENABLE = 1'b1
) (
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] swapped
);

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        localparam int unsigned SRC = ENABLE ? lane_src_bit(unsigned'(i), DATA_W / LANE_W, LANE_W)
                                             : unsigned'(i);
        assign swapped[i] = data[SRC];
    end

endmodule

// File: rtl/wb_avalon_master_bridge.sv
// Registered Wishbone classic slave to Avalon-MM master bridge with
// waitrequest/readdatavalid handling, optional lane swap and a bus timeout.
module wb_avalon_master_bridge
    import sdc_bridge_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter bit          BYTE_SWAP   = 1'b1,
    parameter bit          USE_RDVALID = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   wb_adr_i,
    input  logic [DATA_W-1:0]   wb_dat_i,
    output logic [DATA_W-1:0]   wb_dat_o,
    input  logic [DATA_W/8-1:0] wb_sel_i,
    input  logic                wb_we_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_read,
    output logic                avm_write,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest,
    input  logic                avm_readdatavalid
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT_CYC == 0) ? '0 : TMR_W'(TIMEOUT_CYC - 1);

    bridge_state_t state, next_state;
    logic [TMR_W-1:0] timer;
    logic we_q, aborted;
    logic [DATA_W-1:0] swapped_wdata, swapped_rdata;
    logic [SEL_W-1:0]  swapped_sel;
    logic accept, cmd_clear, capture, timeout, ack_set, err_set;
    logic waiting, expired, suppress;

    byte_lane_swap #(.DATA_W(DATA_W), .LANE_W(8), .ENABLE(BYTE_SWAP)) u_wdata_swap (
        .data(wb_dat_i), .swapped(swapped_wdata));
    byte_lane_swap #(.DATA_W(DATA_W), .LANE_W(8), .ENABLE(BYTE_SWAP)) u_rdata_swap (
        .data(avm_readdata), .swapped(swapped_rdata));
    byte_lane_swap #(.DATA_W(SEL_W), .LANE_W(1), .ENABLE(BYTE_SWAP)) u_sel_swap (
        .data(wb_sel_i), .swapped(swapped_sel));

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        // NOTE: every signal of this block gets a default first, so no path can infer a latch.
        next_state = state;
        accept     = 1'b0;
        cmd_clear  = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        waiting    = (state == CMD) || (state == RDWAIT);
        expired    = (TIMEOUT_CYC != 0) && (timer >= TMR_LAST);
        suppress   = aborted || !wb_cyc_i;
        ack_set    = 1'b0;
        unique case (state)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    accept     = 1'b1;
                    next_state = CMD;
                end
            end
            CMD: begin
                if (!avm_waitrequest) begin
                    cmd_clear = 1'b1;
                    if (we_q || !USE_RDVALID) begin
                        capture    = !we_q;
                        ack_set    = !suppress;
                        next_state = suppress ? IDLE : ACK;
                    end else begin
                        next_state = RDWAIT;
                    end
                end else if (expired) begin
                    cmd_clear  = 1'b1;
                    timeout    = 1'b1;
                    next_state = IDLE;
                end
            end
            RDWAIT: begin
                // Completion is checked before expiry so a same-cycle return wins.
                if (avm_readdatavalid) begin
                    capture    = 1'b1;
                    ack_set    = !suppress;
                    next_state = suppress ? IDLE : ACK;
                end else if (expired) begin
                    timeout    = 1'b1;
                    next_state = IDLE;
                end
            end
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
        err_set = timeout && !suppress;
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments only; every register updates from pre-edge values.
        if (rst_i) begin
            wb_dat_o       <= '0;
            wb_ack_o       <= 1'b0;
            wb_err_o       <= 1'b0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            we_q           <= 1'b0;
            aborted        <= 1'b0;
            timer          <= '0;
        end else begin
            wb_ack_o <= ack_set;
            wb_err_o <= err_set;
            if (accept) begin
                avm_address    <= wb_adr_i;
                avm_writedata  <= swapped_wdata;
                avm_byteenable <= swapped_sel;
                avm_write      <= wb_we_i;
                avm_read       <= !wb_we_i;
                we_q           <= wb_we_i;
                aborted        <= 1'b0;
                timer          <= '0;
            end
            if (cmd_clear) begin
                avm_read  <= 1'b0;
                avm_write <= 1'b0;
            end
            // A master that drops cyc keeps the Avalon side running, but loses its ack/err.
            if (waiting) begin
                timer <= timer + TMR_W'(1);
                if (!wb_cyc_i) aborted <= 1'b1;
            end
            if (capture)      wb_dat_o <= swapped_rdata;
            else if (timeout) wb_dat_o <= '0;
        end
    end

endmodule

// File: tb/tb_wb_avalon_master_bridge.sv
// Randomised self-checking bench: a 32-bit swapping/readdatavalid/timeout-8 bridge
// plus a 64-bit straight-through, waitrequest-only, no-timeout bridge.
module tb_wb_avalon_master_bridge;

    localparam int T = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [31:0] a_adr, a_dat_i, a_dat_o, a_address, a_wdata, a_rdata;
    logic [3:0]  a_sel, a_be;
    logic        a_we, a_cyc, a_stb, a_ack, a_err, a_read, a_write, a_wait, a_rdv;

    logic [31:0] b_adr, b_address;
    logic [63:0] b_dat_i, b_dat_o, b_wdata, b_rdata;
    logic [7:0]  b_sel, b_be;
    logic        b_we, b_cyc, b_stb, b_ack, b_err, b_read, b_write, b_wait, b_rdv;

    wb_avalon_master_bridge #(
        .DATA_W(32), .ADDR_W(32), .BYTE_SWAP(1'b1), .USE_RDVALID(1'b1), .TIMEOUT_CYC(T)
    ) dut_a (
        .clk_i(clk), .rst_i(rst),
        .wb_adr_i(a_adr), .wb_dat_i(a_dat_i), .wb_dat_o(a_dat_o), .wb_sel_i(a_sel),
        .wb_we_i(a_we), .wb_cyc_i(a_cyc), .wb_stb_i(a_stb), .wb_ack_o(a_ack), .wb_err_o(a_err),
        .avm_address(a_address), .avm_writedata(a_wdata), .avm_byteenable(a_be),
        .avm_read(a_read), .avm_write(a_write), .avm_readdata(a_rdata),
        .avm_waitrequest(a_wait), .avm_readdatavalid(a_rdv)
    );

    wb_avalon_master_bridge #(
        .DATA_W(64), .ADDR_W(32), .BYTE_SWAP(1'b0), .USE_RDVALID(1'b0), .TIMEOUT_CYC(0)
    ) dut_b (
        .clk_i(clk), .rst_i(rst),
        .wb_adr_i(b_adr), .wb_dat_i(b_dat_i), .wb_dat_o(b_dat_o), .wb_sel_i(b_sel),
        .wb_we_i(b_we), .wb_cyc_i(b_cyc), .wb_stb_i(b_stb), .wb_ack_o(b_ack), .wb_err_o(b_err),
        .avm_address(b_address), .avm_writedata(b_wdata), .avm_byteenable(b_be),
        .avm_read(b_read), .avm_write(b_write), .avm_readdata(b_rdata),
        .avm_waitrequest(b_wait), .avm_readdatavalid(b_rdv)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] swap32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = v[8*(3-i) +: 8];
        return r;
    endfunction

    function automatic logic [3:0] rev4(input logic [3:0] s);
        return {s[0], s[1], s[2], s[3]};
    endfunction

    // One transfer on bridge A. w = waitrequest cycles, d = cycles from acceptance to
    // readdatavalid, abort_n >= 0 drops cyc at that cycle. Starts and ends at a negedge.
    task automatic a_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int w, input int d,
                          input logic [31:0] rdata, input int abort_n, input string tag);
        int cmd_len = 0, acks = 0, errs = 0, ack_n = -1, err_n = -1, wrong = 0;
        logic [31:0] seen_adr = '0, seen_wd = '0, dat_at_ack = '0;
        logic [3:0]  seen_be = '0;
        bit done;
        int exp_len, exp_end;
        // Reference: cycles counted from the first command cycle; expiry at cycle T-1.
        if (we) begin
            done    = (w <= T - 1);
            exp_len = done ? w + 1 : T;
            exp_end = done ? w + 1 : T;
        end else begin
            done    = (w + d <= T - 1);
            exp_len = (w <= T - 1) ? w + 1 : T;
            exp_end = done ? w + d + 1 : T;
        end
        a_cyc = 1'b1; a_stb = 1'b1; a_we = we; a_adr = adr; a_dat_i = dat; a_sel = sel;
        a_wait = 1'b1; a_rdv = 1'b0; a_rdata = $urandom;
        for (int n = 0; n < 24; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 0) begin
                a_adr = $urandom; a_dat_i = $urandom; a_sel = 4'($urandom); a_we = 1'($urandom);
            end
            if (a_read || a_write) begin
                cmd_len++;
                seen_adr = a_address; seen_wd = a_wdata; seen_be = a_be;
            end
            if ((a_read && we) || (a_write && !we)) wrong++;
            if (a_ack) begin
                acks++;
                if (ack_n < 0) begin ack_n = n; dat_at_ack = a_dat_o; end
                a_cyc = 1'b0; a_stb = 1'b0;
            end
            if (a_err) begin
                errs++;
                if (err_n < 0) err_n = n;
                a_cyc = 1'b0; a_stb = 1'b0;
            end
            if (n == abort_n) begin a_cyc = 1'b0; a_stb = 1'b0; end
            a_wait  = (n < w);
            a_rdv   = !we && (n == w + d);
            a_rdata = a_rdv ? rdata : $urandom;
        end
        a_cyc = 1'b0; a_stb = 1'b0; a_wait = 1'b0; a_rdv = 1'b0;
        check($sformatf("%s.cmd_len", tag), 64'(cmd_len), 64'(abort_n >= 0 ? w + 1 : exp_len));
        check($sformatf("%s.cmd_kind", tag), 64'(wrong), 64'd0);
        check($sformatf("%s.adr", tag), 64'(seen_adr), 64'(adr));
        check($sformatf("%s.be", tag), 64'(seen_be), 64'(rev4(sel)));
        if (we) check($sformatf("%s.wdata", tag), 64'(seen_wd), 64'(swap32(dat)));
        if (abort_n >= 0) begin
            check($sformatf("%s.acks", tag), 64'(acks), 64'd0);
            check($sformatf("%s.errs", tag), 64'(errs), 64'd0);
        end else if (done) begin
            check($sformatf("%s.acks", tag), 64'(acks), 64'd1);
            check($sformatf("%s.errs", tag), 64'(errs), 64'd0);
            check($sformatf("%s.ack_cycle", tag), 64'(ack_n), 64'(exp_end));
            if (!we) check($sformatf("%s.rdata", tag), 64'(dat_at_ack), 64'(swap32(rdata)));
        end else begin
            check($sformatf("%s.acks", tag), 64'(acks), 64'd0);
            check($sformatf("%s.errs", tag), 64'(errs), 64'd1);
            check($sformatf("%s.err_cycle", tag), 64'(err_n), 64'(exp_end));
            check($sformatf("%s.dat_after_err", tag), 64'(a_dat_o), 64'd0);
        end
    endtask

    // Four reads with stb held high across the acks.
    task automatic a_back_to_back();
        logic [31:0] adrs[4], datas[4];
        int cmds = 0, acks = 0, wide = 0, wrong = 0;
        bit prev_ack = 1'b0, pend = 1'b0;
        for (int i = 0; i < 4; i++) begin adrs[i] = $urandom; datas[i] = $urandom; end
        a_cyc = 1'b1; a_stb = 1'b1; a_we = 1'b0; a_adr = adrs[0]; a_sel = 4'hF;
        a_wait = 1'b0; a_rdv = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (a_write) wrong++;
            a_rdv   = pend;
            a_rdata = (pend && cmds > 0) ? datas[cmds-1] : $urandom;
            pend    = a_read;
            if (a_read) begin
                if (cmds < 4) check($sformatf("b2b.adr%0d", cmds), 64'(a_address), 64'(adrs[cmds]));
                else wrong++;
                cmds++;
            end
            if (a_ack) begin
                if (prev_ack) wide++;
                if (acks < 4) check($sformatf("b2b.rdata%0d", acks), 64'(a_dat_o), 64'(swap32(datas[acks])));
                acks++;
                if (acks < 4) a_adr = adrs[acks];
                else begin a_cyc = 1'b0; a_stb = 1'b0; end
            end
            prev_ack = a_ack;
        end
        a_cyc = 1'b0; a_stb = 1'b0; a_rdv = 1'b0;
        check("b2b.cmds", 64'(cmds), 64'd4);
        check("b2b.acks", 64'(acks), 64'd4);
        check("b2b.ack_width", 64'(wide), 64'd0);
        check("b2b.cmd_kind", 64'(wrong), 64'd0);
    endtask

    // One transfer on bridge B (no swap, data valid with waitrequest low, no timeout).
    task automatic b_xfer(input bit we, input logic [31:0] adr, input logic [63:0] dat,
                          input logic [7:0] sel, input int w, input logic [63:0] rdata,
                          input string tag);
        int cmd_len = 0, acks = 0, errs = 0, ack_n = -1;
        logic [31:0] seen_adr = '0;
        logic [63:0] seen_wd = '0, dat_at_ack = '0;
        logic [7:0]  seen_be = '0;
        b_cyc = 1'b1; b_stb = 1'b1; b_we = we; b_adr = adr; b_dat_i = dat; b_sel = sel;
        b_wait = 1'b1; b_rdata = {$urandom, $urandom};
        for (int n = 0; n < w + 6; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 0) begin b_adr = $urandom; b_dat_i = {$urandom, $urandom}; b_sel = 8'($urandom); end
            if (b_read || b_write) begin
                cmd_len++;
                seen_adr = b_address; seen_wd = b_wdata; seen_be = b_be;
            end
            if (b_ack) begin
                acks++;
                if (ack_n < 0) begin ack_n = n; dat_at_ack = b_dat_o; end
                b_cyc = 1'b0; b_stb = 1'b0;
            end
            if (b_err) errs++;
            b_wait  = (n < w);
            b_rdata = (n == w) ? rdata : {$urandom, $urandom};
        end
        b_cyc = 1'b0; b_stb = 1'b0; b_wait = 1'b0;
        check($sformatf("%s.cmd_len", tag), 64'(cmd_len), 64'(w + 1));
        check($sformatf("%s.adr", tag), 64'(seen_adr), 64'(adr));
        check($sformatf("%s.be", tag), 64'(seen_be), 64'(sel));
        check($sformatf("%s.acks", tag), 64'(acks), 64'd1);
        check($sformatf("%s.errs", tag), 64'(errs), 64'd0);
        check($sformatf("%s.ack_cycle", tag), 64'(ack_n), 64'(w + 1));
        if (we) check($sformatf("%s.wdata", tag), seen_wd, dat);
        else    check($sformatf("%s.rdata", tag), dat_at_ack, rdata);
    endtask

    task automatic check_a_zero(input string tag);
        check($sformatf("%s.cmd", tag), 64'({a_read, a_write}), 64'd0);
        check($sformatf("%s.ack_err", tag), 64'({a_ack, a_err}), 64'd0);
        check($sformatf("%s.dat_o", tag), 64'(a_dat_o), 64'd0);
        check($sformatf("%s.avm_bus", tag), {a_address, a_wdata}, 64'd0);
        check($sformatf("%s.be", tag), 64'(a_be), 64'd0);
    endtask

    initial begin
        bit we;
        int w;
        int late_acks;
        rst = 1'b1;
        a_adr = '0; a_dat_i = '0; a_sel = '0; a_we = 1'b0; a_cyc = 1'b0; a_stb = 1'b0;
        a_rdata = '0; a_wait = 1'b0; a_rdv = 1'b0;
        b_adr = '0; b_dat_i = '0; b_sel = '0; b_we = 1'b0; b_cyc = 1'b0; b_stb = 1'b0;
        b_rdata = '0; b_wait = 1'b0; b_rdv = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_a_zero("reset_a");
        check("reset_b.ctl", 64'({b_read, b_write, b_ack, b_err}), 64'd0);
        check("reset_b.dat_o", b_dat_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        a_xfer(1'b1, 32'h0000_1000, 32'h1122_3344, 4'b0011, 0, 0, 32'h0, -1, "wr_spec");
        a_xfer(1'b0, 32'h0000_2000, 32'h0, 4'hF, 3, 2, 32'hAABB_CCDD, -1, "rd_spec");
        a_xfer(1'b0, 32'h0000_3000, 32'h0, 4'hF, 9, 1, 32'h1234_5678, -1, "rd_stuck");
        a_xfer(1'b1, 32'h0000_3004, 32'h5555_AAAA, 4'b1000, 9, 0, 32'h0, -1, "wr_stuck");
        a_xfer(1'b1, 32'h0000_3008, 32'hCAFE_F00D, 4'b0110, 7, 0, 32'h0, -1, "wr_edge");
        a_xfer(1'b1, 32'h0000_300C, 32'hCAFE_F00D, 4'b0110, 8, 0, 32'h0, -1, "wr_expire");
        a_xfer(1'b0, 32'h0000_3010, 32'h0, 4'hF, 3, 4, 32'h0BAD_CAFE, -1, "rd_edge");
        a_xfer(1'b0, 32'h0000_3014, 32'h0, 4'hF, 3, 5, 32'hFEED_BEEF, -1, "rd_late");
        a_xfer(1'b1, 32'h0000_4000, 32'h0102_0304, 4'b1111, 5, 0, 32'h0, 2, "wr_abort");
        a_xfer(1'b1, 32'h0000_4004, 32'h0A0B_0C0D, 4'b0101, 1, 0, 32'h0, -1, "wr_post_abort");
        a_back_to_back();

        for (int i = 0; i < 30; i++) begin
            we = 1'($urandom);
            if (we) w = int'($urandom_range(0, 9));
            else    w = ($urandom_range(0, 5) == 0) ? 9 : int'($urandom_range(0, 6));
            a_xfer(we, $urandom, $urandom, 4'($urandom), w, int'($urandom_range(1, 4)),
                   $urandom, -1, $sformatf("rand%0d", i));
        end

        // Reset while the read waits for readdatavalid.
        a_xfer(1'b0, 32'h0000_5000, 32'h0, 4'hF, 0, 1, 32'h1357_9BDF, -1, "rd_pre_rst");
        a_cyc = 1'b1; a_stb = 1'b1; a_we = 1'b0; a_adr = 32'h0000_2468; a_sel = 4'hF;
        a_dat_i = 32'h7777_7777; a_wait = 1'b0; a_rdv = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid.cmd_issued", 64'(a_read), 64'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        a_cyc = 1'b0; a_stb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_a_zero("rst_mid");
        rst = 1'b0;
        a_rdv = 1'b1; a_rdata = 32'hDEAD_0001;
        late_acks = 0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk);
            @(negedge clk);
            a_rdv = 1'b0;
            if (a_ack || a_err) late_acks++;
        end
        check("rst_mid.no_ack", 64'(late_acks), 64'd0);
        check("rst_mid.dat_o", 64'(a_dat_o), 64'd0);

        b_xfer(1'b1, 32'h0000_0100, 64'h0102_0304_0506_0708, 8'hF0, 0, 64'h0, "b_wr_spec");
        b_xfer(1'b0, 32'h0000_0108, 64'h0, 8'hFF, 3, 64'hDEAD_BEEF_0123_4567, "b_rd");
        b_xfer(1'b1, 32'h0000_0110, 64'h8899_AABB_CCDD_EEFF, 8'h3C, 20, 64'h0, "b_wr_long");
        for (int i = 0; i < 4; i++)
            b_xfer(1'($urandom), $urandom, {$urandom, $urandom}, 8'($urandom),
                   int'($urandom_range(0, 5)), {$urandom, $urandom}, $sformatf("b_rand%0d", i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
